// File: rtl/lbp_hist.sv
// Frame histogram of LBP codes: counts every qualified code over a frame, then
// streams all bins out over valid/ready, zeroing each bin as it is accepted.
module lbp_hist #(
   parameter int CODE_WIDTH = 8,
   parameter int BIN_WIDTH  = 20
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [CODE_WIDTH-1:0] iPix,
   input  logic                  iLineValid,
   input  logic                  iFrameValid,
   output logic [CODE_WIDTH-1:0] oBinIdx,
   output logic [BIN_WIDTH-1:0]  oBinCount,
   output logic                  oBinValid,
   input  logic                  iBinReady,
   output logic                  oFrameDone,
   output logic                  oDropped,
   output logic                  oBusy
);
   localparam int NBINS = 1 << CODE_WIDTH;
   localparam logic [CODE_WIDTH-1:0] IDX_ONE = {{(CODE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [BIN_WIDTH-1:0]  BIN_ONE = {{(BIN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [BIN_WIDTH-1:0]  BIN_MAX = '1;

   typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DRAIN, READ} state_t;
   state_t state, stateNext;

   logic [BIN_WIDTH-1:0]  binMem [NBINS];
   logic [BIN_WIDTH-1:0]  rdData, wrData, fwdVal;
   logic [CODE_WIDTH-1:0] rdAddr, wrAddr, binIdx;
   logic                  wrEn;
   logic                  fvPrev, frameRise, accumEn, accept;
   logic                  p1Valid, p2Valid, p3Valid;
   logic [CODE_WIDTH-1:0] p1Idx, p2Idx, p3Idx;
   logic [BIN_WIDTH-1:0]  p2Val, p3Val;

   assign frameRise = iFrameValid & ~fvPrev;
   assign accumEn   = iFrameValid & iLineValid &
                      ((state == ACCUM) | ((state == IDLE) & frameRise));
   assign oBinValid = (state == READ);
   assign accept    = oBinValid & iBinReady;
   assign oBinIdx   = binIdx;
   assign oBinCount = oBinValid ? rdData : '0;
   assign oBusy     = (state != IDLE) && (state != ACCUM);

   always_comb begin
      stateNext = state;
      case (state)
         CLEAR:   if (binIdx == '1) stateNext = IDLE;
         IDLE:    if (frameRise) stateNext = ACCUM;
         ACCUM:   if (!iFrameValid) stateNext = DRAIN;
         DRAIN:   if (!p1Valid && !p2Valid) stateNext = READ;
         READ:    if (accept && binIdx == '1) stateNext = IDLE;
         default: stateNext = CLEAR;
      endcase
   end

   // In READ the address runs one ahead on acceptance, so rdData always holds
   // the word being presented and stays put while the consumer stalls.
   always_comb begin
      rdAddr = iPix;
      wrEn   = p2Valid;
      wrAddr = p2Idx;
      wrData = p2Val;
      case (state)
         CLEAR: begin
            wrEn   = 1'b1;
            wrAddr = binIdx;
            wrData = '0;
         end
         DRAIN: rdAddr = binIdx;
         READ: begin
            rdAddr = accept ? binIdx + IDX_ONE : binIdx;
            wrEn   = accept;
            wrAddr = binIdx;
            wrData = '0;
         end
         default: ;
      endcase
   end

   // The memory read misses the two most recent updates; take them from the
   // pipeline instead, newest first.
   always_comb begin
      if (p2Valid && p2Idx == p1Idx) fwdVal = p2Val;
      else if (p3Valid && p3Idx == p1Idx) fwdVal = p3Val;
      else fwdVal = rdData;
   end

   always_ff @(posedge iClk) begin
      rdData <= binMem[rdAddr];
      if (wrEn) binMem[wrAddr] <= wrData;
   end

   always_ff @(posedge iClk) begin
      fvPrev <= iFrameValid;
      p1Idx  <= iPix;
      p2Idx  <= p1Idx;
      p2Val  <= (fwdVal == BIN_MAX) ? fwdVal : fwdVal + BIN_ONE;
      p3Idx  <= p2Idx;
      p3Val  <= p2Val;
      if (iRst) begin
         state      <= CLEAR;
         binIdx     <= '0;
         p1Valid    <= 1'b0;
         p2Valid    <= 1'b0;
         p3Valid    <= 1'b0;
         oFrameDone <= 1'b0;
         oDropped   <= 1'b0;
      end else begin
         state   <= stateNext;
         p1Valid <= accumEn;
         p2Valid <= p1Valid;
         p3Valid <= p2Valid;
         if (state == CLEAR || accept) binIdx <= binIdx + IDX_ONE;
         oFrameDone <= accept && (binIdx == '1);
         oDropped   <= frameRise &&
                       (state == CLEAR || state == DRAIN || state == READ);
      end
   end
endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: a wide-bin and a 2-bit-bin instance share stimulus
// and are checked every readout cycle against a per-frame histogram model.
module tb_lbp_hist;
   localparam int CW = 8;
   localparam int NB = 1 << CW;
   localparam int WA = 20;
   localparam int WB = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CW-1:0] pix = '0;
   logic lv = 1'b0;
   logic fv = 1'b0;
   logic rdy = 1'b1;
   logic toggleRdy = 1'b0;
   int rdyPhase = 0;

   logic [CW-1:0] idxA, idxB;
   logic [WA-1:0] cntA;
   logic [WB-1:0] cntB;
   logic validA, validB, doneA, doneB, dropA, dropB, busyA, busyB;

   lbp_hist #(.CODE_WIDTH(CW), .BIN_WIDTH(WA)) dutA (
      .iClk(clk), .iRst(rst), .iPix(pix), .iLineValid(lv), .iFrameValid(fv),
      .oBinIdx(idxA), .oBinCount(cntA), .oBinValid(validA), .iBinReady(rdy),
      .oFrameDone(doneA), .oDropped(dropA), .oBusy(busyA));

   lbp_hist #(.CODE_WIDTH(CW), .BIN_WIDTH(WB)) dutB (
      .iClk(clk), .iRst(rst), .iPix(pix), .iLineValid(lv), .iFrameValid(fv),
      .oBinIdx(idxB), .oBinCount(cntB), .oBinValid(validB), .iBinReady(rdy),
      .oFrameDone(doneB), .oDropped(dropB), .oBusy(busyB));

   // clock and consumer-ready generation
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (toggleRdy) begin
         rdy = (rdyPhase == 1 || rdyPhase == 2) ? 1'b0 : 1'b1;
         rdyPhase = (rdyPhase + 1) % 4;
      end else begin
         rdy = 1'b1;
      end
   end

   // scoreboard state
   int vectors = 0;
   int miscompares = 0;
   logic [CW-1:0] expIdxQ[$];
   logic [31:0]   expCntQ[$];
   int head[2], wordCnt[2], doneCnt[2], dropCnt[2];
   logic doneNext[2], stallPrev[2];
   logic [31:0] seenCnt[2][NB];
   int expFrames = 0;
   int expDrops = 0;
   logic [CW-1:0] frmPix[$];
   logic frmLv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic monitorDut(input int d, input logic valid, input logic [CW-1:0] idx,
                             input logic [WA-1:0] cnt, input logic done, input logic dropped);
      string tag;
      logic [31:0] satMax, expCnt;
      tag = (d == 0) ? "A" : "B";
      satMax = (d == 0) ? (32'd1 << WA) - 32'd1 : (32'd1 << WB) - 32'd1;
      check({tag, " frame_done"}, {31'd0, done}, {31'd0, doneNext[d]});
      doneNext[d] = 1'b0;
      if (done) doneCnt[d]++;
      if (dropped) dropCnt[d]++;
      if (stallPrev[d]) check({tag, " valid_held"}, {31'd0, valid}, 32'd1);
      stallPrev[d] = valid && !rdy;
      if (valid) begin
         if (head[d] >= expIdxQ.size()) begin
            vectors++;
            miscompares++;
            $display("FAIL %s unexpected_word: got idx %0d, expected no word", tag, idx);
         end else begin
            expCnt = (expCntQ[head[d]] > satMax) ? satMax : expCntQ[head[d]];
            check({tag, " bin_idx"}, 32'(idx), 32'(expIdxQ[head[d]]));
            check({tag, " bin_count"}, 32'(cnt), expCnt);
            if (rdy) begin
               seenCnt[d][idx] = 32'(cnt);
               doneNext[d] = (expIdxQ[head[d]] == '1);
               head[d]++;
               wordCnt[d]++;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         monitorDut(0, validA, idxA, cntA, doneA, dropA);
         monitorDut(1, validB, idxB, {{(WA-WB){1'b0}}, cntB}, doneB, dropB);
      end
   end

   // driver tasks
   task automatic newFrame();
      frmPix.delete();
      frmLv.delete();
   endtask

   task automatic addPix(input logic [CW-1:0] p, input logic l);
      frmPix.push_back(p);
      frmLv.push_back(l);
   endtask

   task automatic runFrame(input bit accepted);
      int hist[NB];
      if (accepted) begin
         for (int b = 0; b < NB; b++) hist[b] = 0;
         for (int i = 0; i < frmPix.size(); i++) if (frmLv[i]) hist[frmPix[i]]++;
         for (int b = 0; b < NB; b++) begin
            expIdxQ.push_back(CW'(b));
            expCntQ.push_back(32'(hist[b]));
         end
         expFrames++;
      end else begin
         expDrops++;
      end
      for (int i = 0; i < frmPix.size(); i++) begin
         @(posedge clk); #1;
         fv = 1'b1;
         pix = frmPix[i];
         lv = frmLv[i];
      end
      @(posedge clk); #1;
      fv = 1'b0;
      lv = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic waitReadout(input string name);
      int n;
      n = 0;
      while (doneCnt[0] < expFrames && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL %s readout_timeout: got %0d frames done, expected %0d", name, doneCnt[0], expFrames);
      end
      check({name, " words_A"}, 32'(wordCnt[0]), 32'(expFrames * NB));
      check({name, " words_B"}, 32'(wordCnt[1]), 32'(expFrames * NB));
      check({name, " done_B"}, 32'(doneCnt[1]), 32'(expFrames));
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no summary in time, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         head[d] = 0; wordCnt[d] = 0; doneCnt[d] = 0; dropCnt[d] = 0;
         doneNext[d] = 1'b0; stallPrev[d] = 1'b0;
         for (int b = 0; b < NB; b++) seenCnt[d][b] = 32'hFFFF_FFFF;
      end

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst validA", {31'd0, validA}, 32'd0);
      check("rst validB", {31'd0, validB}, 32'd0);
      check("rst doneA", {31'd0, doneA}, 32'd0);
      check("rst dropA", {31'd0, dropA}, 32'd0);
      check("rst idxA", 32'(idxA), 32'd0);
      check("rst cntA", 32'(cntA), 32'd0);
      check("rst cntB", 32'(cntB), 32'd0);
      check("rst busyA", {31'd0, busyA}, 32'd1);
      check("rst busyB", {31'd0, busyB}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // clear sweep keeps the block busy for one cycle per bin
      n = 0;
      @(negedge clk);
      while (busyA && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'd256);
      check("busyB_after_clear", {31'd0, busyB}, 32'd0);

      newFrame(); addPix(8'd0, 1'b1);
      runFrame(1); waitReadout("f1");
      check("f1 bin0", seenCnt[0][0], 32'd1);
      check("f1 bin1", seenCnt[0][1], 32'd0);

      newFrame();
      addPix(8'd5, 1'b1); addPix(8'd5, 1'b1); addPix(8'd5, 1'b1);
      addPix(8'd7, 1'b1); addPix(8'd5, 1'b1);
      runFrame(1); waitReadout("f2");
      check("f2 bin5", seenCnt[0][5], 32'd4);
      check("f2 bin7", seenCnt[0][7], 32'd1);
      check("f2 bin6", seenCnt[0][6], 32'd0);

      newFrame(); addPix(8'd3, 1'b1); addPix(8'd3, 1'b0);
      runFrame(1); waitReadout("f3");
      check("f3 bin3", seenCnt[0][3], 32'd1);

      toggleRdy = 1'b1;
      newFrame();
      addPix(8'd1, 1'b1); addPix(8'd2, 1'b1); addPix(8'd1, 1'b1);
      addPix(8'd255, 1'b1); addPix(8'd1, 1'b1); addPix(8'd2, 1'b1);
      runFrame(1); waitReadout("f4");
      toggleRdy = 1'b0;
      check("f4 bin1", seenCnt[0][1], 32'd3);
      check("f4 bin2", seenCnt[0][2], 32'd2);
      check("f4 bin255", seenCnt[0][255], 32'd1);

      newFrame();
      for (int i = 0; i < 6; i++) addPix(8'd9, 1'b1);
      runFrame(1); waitReadout("f5");
      check("f5 bin9 wide", seenCnt[0][9], 32'd6);
      check("f5 bin9 sat", seenCnt[1][9], 32'd3);

      newFrame();
      addPix(8'd10, 1'b1); addPix(8'd11, 1'b1); addPix(8'd10, 1'b1);
      addPix(8'd12, 1'b1); addPix(8'd13, 1'b1); addPix(8'd10, 1'b1);
      addPix(8'd10, 1'b1); addPix(8'd14, 1'b1); addPix(8'd10, 1'b1);
      runFrame(1); waitReadout("f6");
      check("f6 bin10", seenCnt[0][10], 32'd5);
      check("f6 bin11", seenCnt[0][11], 32'd1);

      // frame started mid-readout is dropped, even once the block goes idle
      newFrame(); addPix(8'd20, 1'b1); addPix(8'd21, 1'b1); addPix(8'd20, 1'b1);
      runFrame(1);
      n = 0;
      while (!(validA && idxA == 8'd100) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idx100: got no bin 100 after %0d cycles, expected bin 100", n);
      end
      newFrame();
      for (int i = 0; i < 200; i++) addPix(8'd50, 1'b1);
      runFrame(0); waitReadout("f7");
      check("f7 bin20", seenCnt[0][20], 32'd2);
      check("f7 bin21", seenCnt[0][21], 32'd1);
      check("f7 drops A", 32'(dropCnt[0]), 32'(expDrops));
      check("f7 drops B", 32'(dropCnt[1]), 32'(expDrops));

      newFrame(); addPix(8'd60, 1'b1);
      runFrame(1); waitReadout("f8");
      check("f8 bin60", seenCnt[0][60], 32'd1);
      check("f8 bin50", seenCnt[0][50], 32'd0);

      newFrame(); addPix(8'd0, 1'b0); addPix(8'd4, 1'b0); addPix(8'd4, 1'b0);
      runFrame(1); waitReadout("f9");
      check("f9 bin4", seenCnt[0][4], 32'd0);

      // frame already high when reset releases is ignored silently
      @(posedge clk); #1;
      rst = 1'b1; fv = 1'b1; lv = 1'b1; pix = 8'd33;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      fv = 1'b0; lv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("hot_reset drops A", 32'(dropCnt[0]), 32'(expDrops));
      newFrame(); addPix(8'd33, 1'b1); addPix(8'd33, 1'b1);
      runFrame(1); waitReadout("f10");
      check("f10 bin33", seenCnt[0][33], 32'd2);
      check("end drops B", 32'(dropCnt[1]), 32'(expDrops));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Frame-level histogram accumulator placed directly downstream of the LBP operator stage.
- Consumes the LBP code stream (pixel plus sync/valid flags) and counts occurrences of each of the 2^CODE_WIDTH codes over every valid pixel of a frame.
- After the frame ends, streams all bins out over a valid/ready interface and clears them (read-and-clear), ready for the next frame.
- Feeds the downstream feature/classifier readout logic.

Parameters:
- CODE_WIDTH, 8, width of LBP code; number of bins NBINS = 2^CODE_WIDTH.
- BIN_WIDTH, 20, width of each bin counter; saturating.

Ports:
- iClk  in  1  sole clock, rising edge.
- iRst  in  1  synchronous, active-high reset.
- iPix  in  CODE_WIDTH  LBP code from upstream.
- iLineValid  in  1  pixel-in-line qualifier.
- iFrameValid  in  1  frame qualifier.
- oBinIdx  out  CODE_WIDTH  index of the presented bin.
- oBinCount  out  BIN_WIDTH  count of the presented bin.
- oBinValid  out  1  bin word valid.
- iBinReady  in  1  consumer accepts the bin word.
- oFrameDone  out  1  one-cycle pulse when the last bin is accepted.
- oDropped  out  1  one-cycle pulse when a frame start is ignored.
- oBusy  out  1  high in every state except IDLE and ACCUM.

Behaviour:
- Reset values: oBinValid=0, oFrameDone=0, oDropped=0, oBinIdx=0, oBinCount=0, oBusy=1. State becomes CLEAR, and iRst has priority over all events.
- States and transitions:
  - CLEAR: writes zero to bins 0..NBINS-1, one per cycle (NBINS cycles), then goes to IDLE.
  - IDLE: on a rising edge of iFrameValid (registered previous value 0, current 1) goes to ACCUM. That first cycle counts if iLineValid=1.
  - ACCUM: each cycle with iFrameValid & iLineValid increments bin[iPix]. On iFrameValid falling to 0, goes to DRAIN.
  - DRAIN: waits until the pipeline is empty (at most 3 cycles), then goes to READ with index 0.
  - READ: presents bins 0..NBINS-1 in ascending order. Each accepted word writes zero to that bin. After index NBINS-1 is accepted, pulses oFrameDone in the following cycle and goes to IDLE.
- Accumulation pipeline:
  - Read-modify-write through a synchronous-read bin memory, 2-3 stage pipeline.
  - Back-to-back identical or closely spaced codes must forward the in-flight value. Every qualified pixel counts exactly once, at 1 pixel/clock with no stalls.
- Saturation: a bin at 2^BIN_WIDTH-1 stays at that value; no wrap.
- Readout handshake:
  - A word transfers in a cycle where oBinValid & iBinReady.
  - While oBinValid=1 and iBinReady=0, oBinIdx and oBinCount are held stable.
  - oBinValid never drops before acceptance.
  - Sustained iBinReady=1 yields one bin per cycle after the first word. The first word is valid no later than 3 cycles after entering READ.
- Frames during CLEAR, DRAIN or READ:
  - A rising edge of iFrameValid in any of these states pulses oDropped for one cycle.
  - That entire frame is ignored, even if the state reaches IDLE mid-frame. Accumulation begins only on a fresh rising edge seen in IDLE.
- iFrameValid high at reset release is not a rising edge; that frame is ignored without oDropped.
- Pixels with iLineValid=0, or with iFrameValid=0, are never counted.
- A zero-pixel frame (iFrameValid pulses with no iLineValid) still produces a full readout of NBINS zero words.

Test Plan:
- Reset released, iFrameValid=0 → oBusy=1 for exactly 256 cycles, then 0. A subsequent 1-pixel frame (code 0) reads out bin0=1 and all other bins 0.
- Frame with consecutive codes 5,5,5,7,5 and iBinReady=1 → readout bin5=4, bin7=1, all other bins 0. Exactly 256 words, indices 0..255 in order, then one oFrameDone pulse.
- Frame with codes 3,3 where iLineValid=0 on the second pixel → bin3=1.
- iBinReady toggled 1,0,0,1 during readout → oBinIdx and oBinCount held while ready=0. No word is duplicated or skipped.
- BIN_WIDTH=2, frame of six pixels all code 9 → bin9=3 (saturated).
- Second frame starts while READ is at index 100 → one oDropped pulse. The current readout is unaffected, and the next accepted frame's bins exclude the dropped frame's pixels.
